// File: rtl/uart_pkg.sv
// Shared UART definitions: line-format encodings, receiver FSM states and
// the parity helper used by both uart_tx and uart_rx.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Code 3 is deliberately folded into odd parity.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] sel);
        logic p;
        case (sel)
            PAR_NONE: p = 1'b0;
            PAR_EVEN: p = ^data;
            default:  p = ~^data;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous level input; flops reset to 1
// so an idle-high line does not produce a spurious edge out of reset.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic mclk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) ff <= '1;
        else          ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver with mid-bit sampling: 8 data bits, optional even/odd parity,
// one or two stop bits. Frame config is captured at the start edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        mclk,
    input  logic        n_reset,
    input  logic [15:0] baudrate,
    input  logic [1:0]  parity_sel,
    input  logic        stop_sel,
    input  logic        rxd,
    output logic [7:0]  rdata,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    logic        rxd_s, rxd_q, fall;
    rx_state_t   state;
    logic [15:0] cnt, baud_l;
    logic [3:0]  idx;
    logic [7:0]  shift;
    logic [1:0]  par_l;
    logic        stop2_l, second, perr, ferr;
    logic        bit_end;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .mclk    (mclk),
        .n_reset (n_reset),
        .d       (rxd),
        .q       (rxd_s)
    );

    assign fall    = rxd_q & ~rxd_s;
    assign bit_end = (cnt == baud_l);

    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= RX_IDLE;
            rxd_q      <= 1'b1;
            cnt        <= '0;
            baud_l     <= '0;
            idx        <= '0;
            shift      <= '0;
            par_l      <= PAR_NONE;
            stop2_l    <= STOP_1;
            second     <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            rdata      <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rxd_q    <= rxd_s;
            rx_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state   <= RX_START;
                        busy    <= 1'b1;
                        baud_l  <= baudrate;
                        par_l   <= parity_sel;
                        stop2_l <= stop_sel;
                        second  <= 1'b0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                    end
                end
                RX_START: begin
                    if (cnt == (baud_l >> 1)) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rxd_s) begin
                            state <= RX_DATA;
                        end else begin
                            // glitch shorter than half a bit: drop it silently
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        shift[idx[2:0]] <= rxd_s;
                        idx        <= idx + 4'd1;
                        if (idx == 4'd7) state <= (par_l != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        perr  <= (rxd_s != parity_bit(shift, par_l));
                        state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop2_l && !second) begin
                            second <= 1'b1;
                            ferr   <= ferr | ~rxd_s;
                        end else begin
                            state      <= RX_IDLE;
                            busy       <= 1'b0;
                            rx_valid   <= 1'b1;
                            rdata      <= shift;
                            parity_err <= perr;
                            frame_err  <= ferr | ~rxd_s;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that sits directly downstream of the team's UART transmitter, on the loopback path.
- Takes the same `baudrate`, `parity_sel` and `stop_sel` configuration as the transmitter.
- Deserialises 8N1/8E1/8O1/8N2/8E2/8O2 frames from an asynchronous `rxd` line.
- Uses mid-bit sampling.
- Presents each byte with a one-cycle valid pulse plus parity and framing error flags.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `rxd` metastability synchroniser (minimum 2).

Ports:
- mclk  input  1  system clock
- n_reset  input  1  reset
- baudrate  input  16  bit period minus 1, in mclk cycles (bit period = baudrate+1; must be >= 3)
- parity_sel  input  2  0 none, 1 even, 2 odd, 3 treated as odd
- stop_sel  input  1  0 one stop bit, 1 two stop bits
- rxd  input  1  serial line, idle high, asynchronous to mclk
- rdata  output  8  last received byte, LSB first on line
- rx_valid  output  1  one-cycle pulse, rdata/parity_err/frame_err valid
- parity_err  output  1  parity mismatch for the frame flagged by rx_valid
- frame_err  output  1  any sampled stop bit was 0 for that frame
- busy  output  1  high from start-edge detection until the frame completes or is aborted

Behaviour:
- Reset: n_reset, asynchronous, active-low; clock mclk.
  - All flops clear. Synchroniser flops reset to 1 (line idle).
  - Outputs: rdata=0x00, rx_valid=0, parity_err=0, frame_err=0, busy=0.
- Synchroniser: rxd passes through SYNC_STAGES flops, giving rxd_s. A falling edge is rxd_s=0 while the previous rxd_s=1.
- Counters:
  - Bit-time counter `cnt`, 16 bits. Cleared on every state entry. Counts 0..baudrate, then wraps to 0.
  - Half point is baudrate>>1.
  - Bit index `idx`, 4 bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - busy=0.
  - On a falling edge of rxd_s: go to START, cnt=0, busy=1.
  - At the same time latch parity_sel, stop_sel and baudrate into shadow registers. Later config changes do not affect the frame in flight.
- START:
  - When cnt == half: if rxd_s==0, go to DATA with cnt=0 and idx=0.
  - Otherwise it is a false start (glitch): return to IDLE, no rx_valid, no error flags changed.
- DATA:
  - When cnt == baudrate (one full bit period after the previous sample point), shift rxd_s into shift[idx] and increment idx.
  - After the 8th sample: go to PARITY if the latched parity is nonzero, else STOP.
- PARITY:
  - Sample at cnt == baudrate.
  - Expected bit is XOR of the 8 data bits for even; its inverse for odd (and for code 3).
  - Store the mismatch internally. Go to STOP.
- STOP:
  - Sample at cnt == baudrate. Any 0 sets the internal frame error.
  - With stop_sel=1, take a second sample one bit period later.
  - After the final stop sample, in the next cycle:
    - rdata <= shift; parity_err and frame_err <= internal flags;
    - rx_valid = 1 for exactly one cycle;
    - FSM in IDLE, busy=0.
- Latency: rx_valid rises 1 cycle after the final stop-bit sample, which is about half a bit before the transmitter's stop bit ends. A falling edge in the cycle rx_valid is high is accepted as a new start.
- Holding: rdata, parity_err and frame_err hold until the next rx_valid. They are not cleared by a false start.
- Framing error: the frame is still delivered (rx_valid=1, frame_err=1). A line held low (break) is then seen as a new start only after rxd_s returns high and falls again.
- Mid-frame reset: immediate abort to IDLE with reset values. The partial frame is discarded.

Decomposition:
- Shared package `uart_pkg`:
  - parity encodings PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - STOP_1=0, STOP_2=1;
  - rx FSM state enum (3-bit);
  - a function computing the parity bit from data and parity_sel, shared with uart_tx.
- One sub-module: `uart_sync` (SYNC_STAGES-deep, reset-to-1 synchroniser). Reusable for other async inputs.

Test Plan:
- baudrate=15, 8N1, line carries 0xA5 -> exactly one rx_valid pulse, rdata=0xA5, parity_err=0, frame_err=0, busy high about 9.5 bit times.
- baudrate=15, 8E1, 0x3C with parity bit 0 -> rdata=0x3C, parity_err=0. Same byte with parity bit 1 -> parity_err=1. 8O1, 0x01, parity bit 0 -> parity_err=0.
- 8N2, 0x5A, second stop bit driven 0 -> rdata=0x5A, frame_err=1, rx_valid pulses once.
- Glitch: rxd low for 4 cycles at baudrate=15 -> busy pulses, returns to IDLE, no rx_valid, rdata unchanged.
- Loopback with uart_tx, baudrate=7, 8O2, back-to-back 0x00, 0xFF, 0x81 -> three rx_valid pulses in order, all error flags 0. parity_sel flipped mid-frame does not corrupt the current frame.
- Deassert-then-assert n_reset during DATA of 0xC3 -> all outputs return to reset values, no rx_valid. The next clean frame 0x99 is received correctly.
